regbank_arbiter: RTL and testbench

REGBANK_ARBITER -- requirements
Module: regbank_arbiter

---
 rtl/regbank_arbiter_pkg.sv | 12 +
 rtl/rr_arb2.sv | 14 +
 rtl/regbank_arbiter.sv | 157 +++++++++++++++
 tb/tb_regbank_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_arbiter_pkg.sv
// Shared widths and FSM encoding for the two-requester register-bank arbiter.
package regbank_arbiter_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: on a tie the requester that did not own the bank last wins.
module rr_arb2
  import regbank_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_owner,
  output logic o_any,
  output logic o_pick
);
  assign o_any  = i_req0 | i_req1;
  // o_pick = 1 selects requester 1.
  assign o_pick = (i_req0 & i_req1) ? ~i_last_owner : i_req1;
endmodule

// File: rtl/regbank_arbiter.sv
// Arbitrates a single-port register bank between a core (0) and a loader (1),
// with burst-limited fairness, lock override and registered read return.
module regbank_arbiter
  import regbank_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic                we0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  output logic                gnt0,
  output logic                gnt1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [ADDR_W-1:0]   rb_addr_in,
  output logic [DATA_W-1:0]   rb_data_in,
  output logic                rb_write_en,
  output logic [ADDR_W-1:0]   rb_addr_out,
  input  logic [DATA_W-1:0]   rb_data_out,
  output state_t              o_state,
  output logic [BURST_W-1:0]  o_burst_cnt
);
  localparam logic [BURST_W-1:0] LP_MAX    = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] LP_MAX_M1 = BURST_W'(MAX_BURST - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_owner;
  logic                w_next_last_owner;
  logic [BURST_W-1:0]  r_burst_cnt;
  logic [BURST_W-1:0]  w_next_burst_cnt;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_xfer0;
  logic                w_xfer1;
  logic                w_xfer;
  logic                w_last_beat;
  logic                w_arb_any;
  logic                w_arb_pick;

  // Handshake: req_k is the valid, gnt_k the ready; a transfer happens in
  // exactly those cycles where both are high, and nowhere else.
  assign w_gnt0      = (r_state == OWN0);
  assign w_gnt1      = (r_state == OWN1);
  assign w_xfer0     = w_gnt0 & req0;
  assign w_xfer1     = w_gnt1 & req1;
  assign w_xfer      = w_xfer0 | w_xfer1;
  assign w_last_beat = (r_burst_cnt >= LP_MAX_M1);

  rr_arb2 u_rr_arb2 (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last_owner (r_last_owner),
    .o_any        (w_arb_any),
    .o_pick       (w_arb_pick)
  );

  always_comb begin
    w_next_state      = r_state;
    w_next_last_owner = r_last_owner;
    case (r_state)
      IDLE: begin
        if (w_arb_any) w_next_state = w_arb_pick ? OWN1 : OWN0;
      end
      OWN0: begin
        if (!req0) begin
          w_next_state      = req1 ? OWN1 : IDLE;
          w_next_last_owner = 1'b0;
        end else if (!lock0 && req1 && w_last_beat) begin
          w_next_state      = OWN1;
          w_next_last_owner = 1'b0;
        end
      end
      OWN1: begin
        if (!req1) begin
          w_next_state      = req0 ? OWN0 : IDLE;
          w_next_last_owner = 1'b1;
        end else if (!lock1 && req0 && w_last_beat) begin
          w_next_state      = OWN0;
          w_next_last_owner = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The counter restarts on every ownership change and sticks at the limit under lock.
  always_comb begin
    w_next_burst_cnt = r_burst_cnt;
    if (w_next_state != r_state) begin
      w_next_burst_cnt = '0;
    end else if (w_xfer && (r_burst_cnt != LP_MAX)) begin
      w_next_burst_cnt = r_burst_cnt + BURST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_burst_cnt  <= '0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_owner <= w_next_last_owner;
      r_burst_cnt  <= w_next_burst_cnt;
      r_rvalid0    <= w_xfer0 & ~we0;
      r_rvalid1    <= w_xfer1 & ~we1;
      if (w_xfer0 && !we0) r_rdata0 <= rb_data_out;
      if (w_xfer1 && !we1) r_rdata1 <= rb_data_out;
    end
  end

  // Write enable is gated by rst_n so a write coinciding with reset never lands.
  always_comb begin
    rb_addr_in  = '0;
    rb_data_in  = '0;
    rb_write_en = 1'b0;
    if (w_gnt0) begin
      rb_addr_in  = addr0;
      rb_data_in  = wdata0;
      rb_write_en = req0 & we0 & rst_n;
    end else if (w_gnt1) begin
      rb_addr_in  = addr1;
      rb_data_in  = wdata1;
      rb_write_en = req1 & we1 & rst_n;
    end
  end

  assign rb_addr_out = rb_addr_in;
  assign gnt0        = w_gnt0;
  assign gnt1        = w_gnt1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign o_state     = r_state;
  assign o_burst_cnt = r_burst_cnt;
endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: vector table plus directed lock/handoff/reset sequences,
// with a register-bank model and a read-return scoreboard.
module tb_regbank_arbiter;
  import regbank_arbiter_pkg::*;

  typedef struct {
    logic               rst_n;
    logic               req0;
    logic               req1;
    logic               lock0;
    logic               lock1;
    logic               we0;
    logic               we1;
    logic [ADDR_W-1:0]  addr0;
    logic [ADDR_W-1:0]  addr1;
    logic [DATA_W-1:0]  wdata0;
    logic [DATA_W-1:0]  wdata1;
    logic               e_gnt0;
    logic               e_gnt1;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req0, req1, lock0, lock1, we0, we1;
  logic [ADDR_W-1:0]  addr0, addr1;
  logic [DATA_W-1:0]  wdata0, wdata1;
  logic               gnt0, gnt1, rvalid0, rvalid1, rb_write_en;
  logic [DATA_W-1:0]  rdata0, rdata1, rb_data_in, rb_data_out;
  logic [ADDR_W-1:0]  rb_addr_in, rb_addr_out;
  state_t             o_state;
  logic [BURST_W-1:0] o_burst_cnt;

  logic [DATA_W-1:0]  bank [16];
  logic [DATA_W-1:0]  ref_mem [16];
  logic [DATA_W-1:0]  exp_q0[$];
  logic [DATA_W-1:0]  exp_q1[$];
  int                 due_q0[$];
  int                 due_q1[$];
  int                 cyc_cnt = 0;
  int                 n_chk = 0;
  int                 n_bad = 0;
  logic               mon_on = 1'b0;
  vec_t               tbl[$];
  vec_t               v;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  regbank_arbiter #(.MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rb_addr_in(rb_addr_in), .rb_data_in(rb_data_in), .rb_write_en(rb_write_en),
    .rb_addr_out(rb_addr_out), .rb_data_out(rb_data_out),
    .o_state(o_state), .o_burst_cnt(o_burst_cnt)
  );

  // Register bank model: combinational read, write at the clock edge.
  always @(posedge clk) begin
    if (cyc_cnt == 0) begin
      for (int i = 0; i < 16; i++) bank[i] <= 16'(16'hC000 + i);
    end else if (rb_write_en) begin
      bank[rb_addr_in] <= rb_data_in;
    end
  end
  assign rb_data_out = bank[rb_addr_out];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t row(input logic rst, q0, q1, w0, w1,
                               input logic [ADDR_W-1:0] a0, a1,
                               input logic [DATA_W-1:0] d0, d1,
                               input logic g0, g1);
    vec_t r;
    r.rst_n = rst;  r.req0 = q0;  r.req1 = q1;  r.lock0 = 1'b0;  r.lock1 = 1'b0;
    r.we0 = w0;     r.we1 = w1;   r.addr0 = a0; r.addr1 = a1;
    r.wdata0 = d0;  r.wdata1 = d1; r.e_gnt0 = g0; r.e_gnt1 = g1;
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; drives, checks mid-cycle, updates the model, steps one cycle.
  task automatic apply_row(input vec_t r, input string tag);
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              ewe;
    rst_n = r.rst_n;  req0 = r.req0;  req1 = r.req1;  lock0 = r.lock0;  lock1 = r.lock1;
    we0 = r.we0;      we1 = r.we1;    addr0 = r.addr0; addr1 = r.addr1;
    wdata0 = r.wdata0; wdata1 = r.wdata1;
    #3;
    ea  = r.e_gnt0 ? r.addr0  : (r.e_gnt1 ? r.addr1  : '0);
    ed  = r.e_gnt0 ? r.wdata0 : (r.e_gnt1 ? r.wdata1 : '0);
    ewe = r.rst_n & ((r.e_gnt0 & r.req0 & r.we0) | (r.e_gnt1 & r.req1 & r.we1));
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(r.e_gnt0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(r.e_gnt1));
    chk({tag, ".we"}, 32'(rb_write_en), 32'(ewe));
    chk({tag, ".addr_in"}, 32'(rb_addr_in), 32'(ea));
    chk({tag, ".addr_out"}, 32'(rb_addr_out), 32'(ea));
    chk({tag, ".data_in"}, 32'(rb_data_in), 32'(ed));
    if (r.rst_n && r.e_gnt0 && r.req0 && !r.we0) begin
      exp_q0.push_back(ref_mem[r.addr0]);
      due_q0.push_back(cyc_cnt + 1);
    end
    if (r.rst_n && r.e_gnt1 && r.req1 && !r.we1) begin
      exp_q1.push_back(ref_mem[r.addr1]);
      due_q1.push_back(cyc_cnt + 1);
    end
    if (ewe) ref_mem[ea] = ed;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      if (due_q0.size() > 0 && due_q0[0] == cyc_cnt) begin
        chk("sb.rvalid0", 32'(rvalid0), 32'd1);
        chk("sb.rdata0", 32'(rdata0), 32'(exp_q0[0]));
        void'(exp_q0.pop_front());
        void'(due_q0.pop_front());
      end else begin
        chk("sb.rvalid0_quiet", 32'(rvalid0), 32'd0);
      end
      if (due_q1.size() > 0 && due_q1[0] == cyc_cnt) begin
        chk("sb.rvalid1", 32'(rvalid1), 32'd1);
        chk("sb.rdata1", 32'(rdata1), 32'(exp_q1[0]));
        void'(exp_q1.pop_front());
        void'(due_q1.pop_front());
      end else begin
        chk("sb.rvalid1_quiet", 32'(rvalid1), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'(16'hC000 + i);

    // Main vector table: write/read round trip, tie + early release, burst alternation.
    tbl.push_back(row(1, 1, 0, 1, 0, 3, 0, 16'hA5A5, 0, 0, 0));
    tbl.push_back(row(1, 1, 0, 1, 0, 3, 0, 16'hA5A5, 0, 1, 0));
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 0, 0, 0, 3, 0, 0, 0, 1, 0));
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 1, 1, 1, 5, 6, 16'h0055, 16'h0066, 0, 0));
    tbl.push_back(row(1, 1, 1, 1, 1, 5, 6, 16'h0055, 16'h0066, 1, 0));
    tbl.push_back(row(1, 0, 1, 1, 1, 5, 6, 16'h0055, 16'h0066, 1, 0));
    tbl.push_back(row(1, 0, 1, 1, 1, 5, 6, 16'h0055, 16'h0066, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 5, 6, 16'h0055, 16'h0066, 0, 1));
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 1, 1, 1, 8, 9, 16'h0800, 16'h0900, 0, 0));
    for (int j = 0; j < 12; j++) begin
      tbl.push_back(row(1, 1, 1, 1, 1, 8, 9, 16'(16'h0800 + j), 16'(16'h0900 + j),
                        ((j / 4) % 2) == 0, ((j / 4) % 2) == 1));
    end
    tbl.push_back(row(1, 0, 0, 1, 1, 8, 9, 0, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt0", 32'(gnt0), 32'd0);
    chk("rst.gnt1", 32'(gnt1), 32'd0);
    chk("rst.rvalid0", 32'(rvalid0), 32'd0);
    chk("rst.rvalid1", 32'(rvalid1), 32'd0);
    chk("rst.rdata0", 32'(rdata0), 32'd0);
    chk("rst.rdata1", 32'(rdata1), 32'd0);
    chk("rst.burst_cnt", 32'(o_burst_cnt), 32'd0);
    chk("rst.state", 32'(o_state), 32'(IDLE));
    chk("rst.we", 32'(rb_write_en), 32'd0);
    mon_on = 1'b1;

    foreach (tbl[i]) apply_row(tbl[i], $sformatf("row%0d", i));

    // Lock: loader holds the bank for 10 transfers while the core waits.
    v = row(1, 0, 1, 0, 1, 0, 1, 0, 16'h0101, 0, 0);
    v.lock1 = 1'b1;
    apply_row(v, "lock_start");
    for (int i = 1; i <= 10; i++) begin
      v = row(1, 1, 1, 0, 1, 4, 1, 0, 16'(16'h0100 + i), 0, 1);
      v.lock1 = 1'b1;
      apply_row(v, $sformatf("lock%0d", i));
      chk($sformatf("lock_cnt%0d", i), 32'(o_burst_cnt), (i < 4) ? i : 4);
    end
    v = row(1, 1, 0, 0, 1, 4, 1, 0, 0, 0, 1);
    v.lock1 = 1'b1;
    apply_row(v, "lock_drop");
    apply_row(row(1, 1, 0, 0, 0, 4, 0, 0, 0, 1, 0), "lock_after");
    apply_row(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "lock_rel");
    apply_row(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lock_idle");

    // Handoff: loader's last burst write to addr 7 is read by the core next cycle.
    apply_row(row(1, 0, 1, 0, 1, 0, 7, 0, 16'h1111, 0, 0), "ho0");
    for (int i = 1; i <= 3; i++)
      apply_row(row(1, 1, 1, 0, 1, 7, 7, 0, 16'h1111, 0, 1), $sformatf("ho%0d", i));
    apply_row(row(1, 1, 1, 0, 1, 7, 7, 0, 16'h1234, 0, 1), "ho4");
    apply_row(row(1, 1, 1, 0, 1, 7, 7, 0, 16'hBAD1, 1, 0), "ho5");
    apply_row(row(1, 0, 1, 0, 0, 7, 7, 0, 0, 1, 0), "ho6");
    apply_row(row(1, 0, 1, 0, 0, 7, 7, 0, 0, 0, 1), "ho7");
    apply_row(row(1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1), "ho8");
    apply_row(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ho9");
    chk("ho.rdata0_hold", 32'(rdata0), 32'h1234);
    chk("ho.rdata1_hold", 32'(rdata1), 32'h1234);

    // Reset during a granted write to addr 2, then during a granted read.
    apply_row(row(1, 1, 0, 1, 0, 2, 0, 16'hDEAD, 0, 0, 0), "rw_a");
    apply_row(row(0, 1, 0, 1, 0, 2, 0, 16'hDEAD, 0, 1, 0), "rw_b");
    chk("rw.gnt0", 32'(gnt0), 32'd0);
    chk("rw.gnt1", 32'(gnt1), 32'd0);
    chk("rw.rvalid0", 32'(rvalid0), 32'd0);
    chk("rw.rdata0", 32'(rdata0), 32'd0);
    chk("rw.rdata1", 32'(rdata1), 32'd0);
    chk("rw.burst_cnt", 32'(o_burst_cnt), 32'd0);
    chk("rw.state", 32'(o_state), 32'(IDLE));
    apply_row(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_c");
    apply_row(row(1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0), "rw_d");
    apply_row(row(1, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0), "rw_e");
    apply_row(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rw_f");
    apply_row(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_g");
    apply_row(row(1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0), "rr_h");
    apply_row(row(0, 1, 0, 0, 0, 3, 0, 0, 0, 1, 0), "rr_i");
    apply_row(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rr_j");
    apply_row(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rr_k");

    repeat (2) @(posedge clk);
    #1;
    chk("sb.drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
